// File: rtl/imem_fetch_pkg.sv
// Shared types and default constants for the instruction-fetch sequencer.
package imem_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD  = 32'hFFFF_FFFF;
  localparam int          DEFAULT_IMEM_WORDS = 1024;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {instruction, PC} entries; flush beats push.
module fetch_buffer
  import imem_fetch_pkg::*;
#(
  parameter  int BUF_DEPTH = 2,
  localparam int PW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wr_data,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem [BUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(BUF_DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, buffers fetched words, handles redirect/halt/wrap.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS,
  parameter int          BUF_DEPTH  = 2,
  parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Run,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  output logic        IfValid,
  input  logic        IfReady,
  output logic [31:0] IfInstruction,
  output logic [31:0] IfPC,
  output logic [31:0] IfPCPlus4,
  output logic        Halted,
  output logic [31:0] FetchCount,
  output logic        AlignFault
);

  localparam logic [31:0] MEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam int          CW        = $clog2(BUF_DEPTH + 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d, count_q;
  fetch_entry_t  head, wr_entry;
  logic [CW-1:0] buf_count;
  logic          full, empty, pop, push, can_fetch, is_halt;
  logic          redirect_eff, misaligned;

  // PC arithmetic assumes the operand is already inside the memory window.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return (pc >= MEM_BYTES - 32'd4) ? 32'd0 : pc + 32'd4;
  endfunction

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  assign redirect_eff = Redirect && !fault_q;
  assign misaligned   = (RedirectAddr[1:0] != 2'b00);
  assign AlignFault   = fault_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) fault_q <= 1'b0;
    else if (redirect_eff && misaligned) fault_q <= 1'b1;
  end
`else
  assign redirect_eff = Redirect;
  assign misaligned   = 1'b0;
  assign AlignFault   = 1'b0;
`endif

  assign pop       = !empty && IfReady;
  assign is_halt   = (ImemInstruction == HALT_WORD);
  assign can_fetch = Run && (state_q == FETCH) && !Redirect && (!full || pop);
  assign push      = can_fetch && !is_halt;
  assign wr_entry  = '{instr: ImemInstruction, pc: pc_q};

  fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk    (Clk),
    .rst_n  (Rst),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_eff),
    .wr_data(wr_entry),
    .head   (head),
    .count  (buf_count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (push) count_q <= count_q + 32'd1;
    end
  end

  // Redirect outranks fetch; a halt word parks the PC on itself.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_eff) begin
      if (misaligned) begin
        state_d = HALT;
        pc_d    = RedirectAddr % MEM_BYTES;
      end else begin
        state_d = FETCH;
        pc_d    = (RedirectAddr % MEM_BYTES) & ~32'd3;
      end
    end else if (can_fetch) begin
      if (is_halt) state_d = HALT;
      else         pc_d    = pc_plus4(pc_q);
    end
  end

  assign ImemAddress   = pc_q;
  assign IfValid       = (buf_count != '0);
  assign IfInstruction = empty ? 32'd0 : head.instr;
  assign IfPC          = empty ? 32'd0 : head.pc;
  assign IfPCPlus4     = empty ? 32'd0 : pc_plus4(head.pc);
  assign Halted        = (state_q == HALT);
  assign FetchCount    = count_q;

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the address port of the word-indexed, asynchronous-read instruction memory.
Buffers fetched words in a small FIFO and hands {instruction, PC} to decode over a valid/ready handshake.
Handles branch/jump redirects, buffer flushing, a halt word and end-of-memory wrap.
Sits between InstructionMemory and the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
IMEM_WORDS, 1024, instruction memory depth in words; PC wraps modulo IMEM_WORDS*4.
BUF_DEPTH, 2, fetch-buffer entries; must be at least 1.
HALT_WORD, 32'hFFFF_FFFF, fetched encoding that stops fetch.

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  asynchronous, active-low reset.
Run  in  1  fetch enable; when low, the PC holds and nothing is enqueued.
ImemAddress  out  32  byte address to instruction memory; always equals FetchPC.
ImemInstruction  in  32  combinational read data for ImemAddress, same cycle.
Redirect  in  1  branch/jump taken; single-cycle pulse or level.
RedirectAddr  in  32  redirect target byte address.
IfValid  out  1  buffer head valid.
IfReady  in  1  decode accepts the head.
IfInstruction  out  32  head instruction.
IfPC  out  32  byte address of the head instruction.
IfPCPlus4  out  32  IfPC+4, wrapped modulo IMEM_WORDS*4.
Halted  out  1  fetch stopped by HALT_WORD or alignment fault.
FetchCount  out  32  number of instructions enqueued since reset; wraps at 2^32.
AlignFault  out  1  sticky misaligned-redirect flag; tied to 0 when the feature is off.

Behaviour:
- Reset (Rst=0, asynchronous): FetchPC=RESET_PC, buffer empty, IfValid=0, IfInstruction/IfPC/IfPCPlus4=0, Halted=0, FetchCount=0, AlignFault=0. Reset asserted mid-operation discards buffer contents immediately.
- Handshake: a transfer occurs on a rising edge with IfValid&&IfReady. The head outputs hold stable while IfValid=1 and IfReady=0.
- Enqueue condition: Run && !Halted && !Redirect && (count<BUF_DEPTH || IfValid&&IfReady).
  - Simultaneous dequeue and enqueue while the buffer is full is allowed (full throughput).
- On enqueue: the entry {ImemInstruction, FetchPC} is written; FetchPC<=(FetchPC+4) mod (IMEM_WORDS*4); FetchCount increments.
- Latency: with Run high out of reset, IfValid rises after the first rising edge, with IfPC=RESET_PC.
- No enqueue: FetchPC holds; ImemAddress is stable.
- HALT_WORD fetched: the word is not enqueued, FetchPC holds, Halted<=1. The buffer keeps draining to decode.
- Redirect (highest priority over enqueue; the head is still counted as consumed if IfReady was high):
  - Flush all entries; IfValid=0 next cycle.
  - FetchPC<=RedirectAddr mod (IMEM_WORDS*4) with bits[1:0] forced to 0; Halted<=0.
  - The first target instruction appears one cycle after the flush cycle.
- Redirect while Run=0: the PC and flush still take effect; fetching resumes when Run rises.
- Wrap: a fetch at IMEM_WORDS*4-4 is followed by a fetch at 0; IfPCPlus4 of that entry is 0.
- State: FETCH (Halted=0) and HALT (Halted=1).
  - FETCH->HALT on HALT_WORD, or on an alignment fault.
  - HALT->FETCH on Redirect, except after an alignment fault.

Optional Feature:
FETCH_ALIGN_CHECK_EN:
- When defined: Redirect with RedirectAddr[1:0]!=0 sets AlignFault (sticky until reset) and Halted, and flushes the buffer. FetchPC<=RedirectAddr with its low bits kept as given. Subsequent Redirects are ignored until reset.
- When undefined: low bits are silently masked and AlignFault is constant 0.

Decomposition:
- Package imem_fetch_pkg: typedef fetch_entry_t {instr[31:0], pc[31:0]}; default constants RESET_PC, HALT_WORD, IMEM_WORDS.
- Sub-module fetch_buffer: a BUF_DEPTH-entry synchronous FIFO of fetch_entry_t.
  - Inputs: push, pop, flush. Outputs: head, count, full, empty.
  - Flush has priority over push.

Test Plan:
- Release reset, Run=1, IfReady=1, memory word i = i: IfPC sequence 0,4,8,…; IfInstruction = IfPC>>2; IfValid high from cycle 1; FetchCount=N after N transfers.
- IfReady=0 for 5 cycles: buffer fills to 2 entries; ImemAddress holds at 8; no drop or duplication after IfReady returns to 1.
- Redirect to 32'h40 while full: next cycle IfValid=0; following cycle IfPC=32'h40; old entries never appear.
- Word at 32'h10 = 32'hFFFF_FFFF: entries 0..C delivered; Halted=1; IfValid falls after drain; Redirect to 0 restarts fetch.
- IMEM_WORDS=4, run 6 fetches: IfPC sequence 0,4,8,C,0,4; the entry at C has IfPCPlus4=0.
- With FETCH_ALIGN_CHECK_EN defined, Redirect to 32'h42: AlignFault=1, Halted=1; a later Redirect to 0 is ignored; Rst clears both flags.
